// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment display paths.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  localparam digit_idx_t IdxOnes      = 2'd0;
  localparam digit_idx_t IdxTens      = 2'd1;
  localparam digit_idx_t IdxHundreds  = 2'd2;
  localparam digit_idx_t IdxThousands = 2'd3;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational 4-bit code to active-low seven-segment pattern; codes above 9 show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    unique case (code_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed four-digit common-anode driver with per-frame digit snapshot,
// leading-zero blanking and registered anode/cathode outputs.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  input  logic [3:0] thousands,
  input  logic [3:0] dp_en,
  input  logic       blank,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

  logic [CntW-1:0]  cnt_q, cnt_d;
  digit_idx_t       idx_q, idx_d;
  logic [3:0][3:0]  digit_q, digit_d;
  logic [3:0]       dp_en_q, dp_en_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic             wrap;
  logic             load;
  logic [3:0]       is_zero;
  logic [3:0]       lit;
  logic [3:0]       cur_digit;
  logic [6:0]       dec_seg;

  bcd_to_seg7 u_dec (
    .code_i (cur_digit),
    .seg_o  (dec_seg)
  );

  always_comb begin
    wrap  = (cnt_q == CntMax);
    cnt_d = wrap ? '0 : cnt_q + CntW'(1);
    idx_d = wrap ? idx_q + 2'd1 : idx_q;

    // Snapshot only at the very end of a frame so a frame never mixes old and new digits.
    load    = wrap && (idx_q == IdxThousands);
    digit_d = load ? {thousands, hundreds, tens, ones} : digit_q;
    dp_en_d = load ? dp_en : dp_en_q;

    // Codes above 9 are not zero, so a dash in an upper digit keeps lower zeros lit.
    for (int i = 0; i < 4; i++) begin
      is_zero[i] = (digit_q[i] == 4'd0);
    end
    lit[IdxOnes]      = 1'b1;
    lit[IdxTens]      = !(is_zero[3] && is_zero[2] && is_zero[1]);
    lit[IdxHundreds]  = !(is_zero[3] && is_zero[2]);
    lit[IdxThousands] = !is_zero[3];

    cur_digit = digit_q[idx_q];

    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (!blank && lit[idx_q]) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = dec_seg;
      dp_d  = ~dp_en_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= IdxOnes;
      digit_q <= '0;
      dp_en_q <= '0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      digit_q <= digit_d;
      dp_en_q <= dp_en_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver at REFRESH_DIV=4: table of digit vectors with
// hand-derived per-slot patterns, fed through an expected-output queue every cycle.
module tb_seg7_scan_driver;

  localparam int unsigned Div   = 4;
  localparam int          Frame = 4 * Div;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  typedef struct packed {
    logic [3:0]      th;
    logic [3:0]      hu;
    logic [3:0]      te;
    logic [3:0]      on;
    logic [3:0]      dpe;
    exp_t [3:0]      ex;   // indexed by slot: 0 ones .. 3 thousands
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] ones = '0, tens = '0, hundreds = '0, thousands = '0, dp_en = '0;
  logic       blank = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  seg7_scan_driver #(.REFRESH_DIV(Div)) dut (
    .clk       (clk),
    .reset     (reset),
    .ones      (ones),
    .tens      (tens),
    .hundreds  (hundreds),
    .thousands (thousands),
    .dp_en     (dp_en),
    .blank     (blank),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    failures = 0;
  int    e = 0;        // edges since reset release
  int    shown = 0;    // vector currently held in the snapshot
  int    cur = 0;      // vector currently driven on the inputs
  string phase = "init";
  exp_t  q[$];
  vec_t  vecs[8];

  function automatic exp_t mke(input logic [3:0] a, input logic [6:0] s, input logic d);
    exp_t r;
    r.an = a; r.seg = s; r.dp = d;
    return r;
  endfunction

  function automatic vec_t mkv(input logic [3:0] th, hu, te, on, dpe,
                               input exp_t e0, e1, e2, e3);
    vec_t v;
    v.th = th; v.hu = hu; v.te = te; v.on = on; v.dpe = dpe;
    v.ex[0] = e0; v.ex[1] = e1; v.ex[2] = e2; v.ex[3] = e3;
    return v;
  endfunction

  task automatic compare(input exp_t want);
    checks++;
    if (an !== want.an || seg !== want.seg || dp !== want.dp) begin
      failures++;
      $display("FAIL %s edge=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
               phase, e, an, seg, dp, want.an, want.seg, want.dp);
    end
  endtask

  task automatic tick();
    exp_t want;
    int   slot;
    e++;
    slot = ((e - 1) / Div) % 4;
    want = blank ? mke(4'b1111, 7'b1111111, 1'b1) : vecs[shown].ex[slot];
    if (e % Frame == 0) shown = cur;
    q.push_back(want);
    @(posedge clk);
    #1;
    compare(q.pop_front());
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) begin
      q.push_back(mke(4'b1111, 7'b1111111, 1'b1));
      @(posedge clk);
      #1;
      compare(q.pop_front());
    end
    reset = 1'b0;
    e = 0;
    shown = 0;
  endtask

  task automatic apply_vec(input int i);
    thousands = vecs[i].th;
    hundreds  = vecs[i].hu;
    tens      = vecs[i].te;
    ones      = vecs[i].on;
    dp_en     = vecs[i].dpe;
    cur       = i;
  endtask

  initial begin
    exp_t off;
    off = mke(4'b1111, 7'b1111111, 1'b1);
    vecs[0] = mkv(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000,
                  mke(4'b1110, 7'b1000000, 1'b1), off, off, off);
    vecs[1] = mkv(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000,
                  mke(4'b1110, 7'b0011001, 1'b1), mke(4'b1101, 7'b0110000, 1'b1),
                  mke(4'b1011, 7'b0100100, 1'b1), mke(4'b0111, 7'b1111001, 1'b1));
    vecs[2] = mkv(4'd0, 4'd0, 4'd5, 4'd0, 4'b0000,
                  mke(4'b1110, 7'b1000000, 1'b1), mke(4'b1101, 7'b0010010, 1'b1), off, off);
    vecs[3] = mkv(4'd0, 4'd1, 4'd0, 4'd0, 4'b0000,
                  mke(4'b1110, 7'b1000000, 1'b1), mke(4'b1101, 7'b1000000, 1'b1),
                  mke(4'b1011, 7'b1111001, 1'b1), off);
    vecs[4] = mkv(4'd0, 4'd0, 4'd0, 4'hC, 4'b0001,
                  mke(4'b1110, 7'b0111111, 1'b0), off, off, off);
    vecs[5] = mkv(4'd9, 4'd8, 4'd7, 4'd6, 4'b1010,
                  mke(4'b1110, 7'b0000010, 1'b1), mke(4'b1101, 7'b1111000, 1'b0),
                  mke(4'b1011, 7'b0000000, 1'b1), mke(4'b0111, 7'b0010000, 1'b0));
    vecs[6] = mkv(4'hA, 4'd0, 4'd0, 4'd0, 4'b1111,
                  mke(4'b1110, 7'b1000000, 1'b0), mke(4'b1101, 7'b1000000, 1'b0),
                  mke(4'b1011, 7'b1000000, 1'b0), mke(4'b0111, 7'b0111111, 1'b0));
    vecs[7] = mkv(4'd0, 4'd0, 4'hF, 4'd0, 4'b0100,
                  mke(4'b1110, 7'b1000000, 1'b1), mke(4'b1101, 7'b0111111, 1'b1), off, off);

    @(posedge clk);
    #1;
    phase = "reset";
    do_reset();
    phase = "post_reset_lag";
    compare(off);

    for (int i = 0; i < 8; i++) begin
      phase = $sformatf("vec%0d", i);
      apply_vec(i);
      repeat (2 * Frame) tick();
    end

    // Digits change while the tens slot is showing; old frame must complete untouched.
    phase = "midframe";
    repeat (6) tick();
    apply_vec(5);
    repeat (Frame - 6 + Frame) tick();

    phase = "blank";
    repeat (2) tick();
    blank = 1'b1;
    repeat (3) tick();
    blank = 1'b0;
    repeat (3) tick();

    phase = "seek_hundreds";
    for (int k = 0; k < 2 * Frame && !((e / Div) % 4 == 2 && e % Div == 1); k++) tick();
    phase = "reset_midframe";
    do_reset();
    phase = "restart";
    compare(off);
    repeat (Frame + 4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
